// File: rtl/bus_cycle_ctl.sv
// Initiator-side bus cycle controller: issues one tagged read/write on the NoC bus,
// waits for an ack with the matching ID, and reports completion or timeout.
module bus_cycle_ctl #(
    parameter int unsigned AWID    = 32,
    parameter int unsigned DWID    = 32,
    parameter int unsigned TIMEOUT = 31
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            ce_i,
    input  logic            req_i,
    input  logic            we_i,
    input  logic [AWID-1:0] adr_i,
    input  logic [DWID-1:0] dat_i,
    output logic            busy_o,
    output logic            done_o,
    output logic            err_o,
    output logic [DWID-1:0] dat_o,
    output logic            m_cyc_o,
    output logic            m_stb_o,
    output logic            m_we_o,
    output logic [AWID-1:0] m_adr_o,
    output logic [DWID-1:0] m_dat_o,
    output logic [3:0]      m_rid_o,
    output logic [3:0]      m_wid_o,
    input  logic            m_ack_i,
    input  logic [3:0]      m_rid_i,
    input  logic [3:0]      m_wid_i,
    input  logic [DWID-1:0] m_dat_i
);

    typedef enum logic [1:0] {StIdle, StWait, StRecover} state_e;

    localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

    state_e          state_q, state_d;
    logic [3:0]      tag_q, tag_d;
    logic [7:0]      cnt_q, cnt_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic [DWID-1:0] rdat_q, rdat_d;
    logic            cyc_q, cyc_d;
    logic            we_q, we_d;
    logic [AWID-1:0] adr_q, adr_d;
    logic [DWID-1:0] wdat_q, wdat_d;
    logic [3:0]      rid_q, rid_d;
    logic [3:0]      wid_q, wid_d;
    logic            match;

    // Reads are matched on the read ID, writes on the write ID.
    assign match = m_ack_i && (we_q ? (m_wid_i == tag_q) : (m_rid_i == tag_q));

    always_comb begin
        state_d = state_q;
        tag_d   = tag_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        err_d   = err_q;
        rdat_d  = rdat_q;
        cyc_d   = cyc_q;
        we_d    = we_q;
        adr_d   = adr_q;
        wdat_d  = wdat_q;
        rid_d   = rid_q;
        wid_d   = wid_q;
        busy_d  = busy_q;
        if (ce_i) begin
            done_d = 1'b0;
            err_d  = 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (req_i) begin
                        we_d    = we_i;
                        adr_d   = adr_i;
                        wdat_d  = dat_i;
                        rid_d   = tag_q;
                        wid_d   = tag_q;
                        cyc_d   = 1'b1;
                        cnt_d   = 8'd0;
                        state_d = StWait;
                    end
                end
                StWait: begin
                    // A match on the timeout edge still completes without error.
                    if (match) begin
                        cyc_d   = 1'b0;
                        done_d  = 1'b1;
                        tag_d   = tag_q + 4'd1;
                        state_d = StRecover;
                        if (!we_q) rdat_d = m_dat_i;
                    end else if (cnt_q == CntLast) begin
                        cyc_d   = 1'b0;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                        tag_d   = tag_q + 4'd1;
                        state_d = StRecover;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                StRecover: begin
                    // Level-ack responders must drop ack before the next cycle starts.
                    if (!m_ack_i) state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
            busy_d = (state_d != StIdle);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            tag_q   <= 4'd0;
            cnt_q   <= 8'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            rdat_q  <= '0;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            wdat_q  <= '0;
            rid_q   <= 4'd0;
            wid_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            tag_q   <= tag_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            rdat_q  <= rdat_d;
            cyc_q   <= cyc_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            wdat_q  <= wdat_d;
            rid_q   <= rid_d;
            wid_q   <= wid_d;
        end
    end

    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign err_o   = err_q;
    assign dat_o   = rdat_q;
    assign m_cyc_o = cyc_q;
    assign m_stb_o = cyc_q;
    assign m_we_o  = we_q;
    assign m_adr_o = adr_q;
    assign m_dat_o = wdat_q;
    assign m_rid_o = rid_q;
    assign m_wid_o = wid_q;

endmodule

// File: doc/bus_cycle_ctl.md
Name: bus_cycle_ctl

Overview:
Initiator-side bus cycle controller; the counterpart to the slave-side acknowledge generators on the NoC bus. It accepts a single read or write request from a core, drives cyc/stb with a 4-bit transaction tag, and waits for an acknowledge carrying the matching read or write ID. It returns read data, or flags an error if no matching ack arrives within TIMEOUT enabled clocks.

Parameters:
AWID, 32, address width
DWID, 32, data width
TIMEOUT, 31, enabled clocks in WAIT before error (1..255)

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, synchronous, active-high
ce_i  in  1  clock enable; low = all state, counters and outputs hold
req_i  in  1  core request (sampled in IDLE only)
we_i  in  1  request is write
adr_i  in  AWID  request address
dat_i  in  DWID  write data
busy_o  out  1  high in WAIT and RECOVER
done_o  out  1  one-cycle completion pulse
err_o  out  1  one-cycle timeout pulse, coincident with done_o
dat_o  out  DWID  captured read data
m_cyc_o  out  1  bus cycle
m_stb_o  out  1  bus strobe
m_we_o  out  1  bus write
m_adr_o  out  AWID  bus address
m_dat_o  out  DWID  bus write data
m_rid_o  out  4  read tag
m_wid_o  out  4  write tag
m_ack_i  in  1  responder ack, level
m_rid_i  in  4  returned read ID
m_wid_i  in  4  returned write ID
m_dat_i  in  DWID  read data

Behaviour:
- Reset: state IDLE, tag=0, timeout count=0; all outputs 0, including dat_o. Reset mid-cycle: cyc/stb low the next cycle, no done_o/err_o.
- All outputs registered. Every transition requires ce_i=1.
- IDLE: on req_i=1, latch we_i/adr_i/dat_i onto m_we_o/m_adr_o/m_dat_o, drive m_rid_o=m_wid_o=tag, set cyc=stb=1, clear count, go WAIT. Request at edge N puts cyc high from N+1.
- WAIT: ack matches when m_ack_i=1 and (read: m_rid_i==tag; write: m_wid_i==tag). A mismatched ack is ignored and does not reset the count.
- WAIT, match: cyc/stb=0; on read, dat_o<=m_dat_i; done_o=1 for one cycle; tag<=tag+1 (mod 16 wrap 15->0); go RECOVER. Ack sampled at edge N gives done_o high during N+1.
- WAIT, no match: count+1. When count reaches TIMEOUT-1 with no match: cyc/stb=0; done_o=err_o=1; dat_o unchanged; tag still increments; go RECOVER.
- Ack match and timeout on the same edge: ack wins, err_o=0.
- RECOVER: minimum one cycle. Stays while m_ack_i=1 (level-ack responders), then IDLE.
- req_i outside IDLE is ignored, not queued. The core must re-request after done_o.
- A write with a zero-latency responder (ack present on the first WAIT edge) completes on that edge.
- m_we_o/m_adr_o/m_dat_o/tags hold their values after the cycle ends.

Test Plan:
- Read, adr=0x1000, responder acks 3 clocks after stb with rid=0, data 0xDEADBEEF -> cyc high 4 cycles, done_o one pulse, dat_o=0xDEADBEEF, err_o=0, tag becomes 1.
- Write, adr=0x20, dat=0x55AA, ack with wid=1 on first WAIT edge -> done_o the next cycle, m_we_o=1, m_dat_o=0x55AA, dat_o unchanged.
- No ack, TIMEOUT=31 -> cyc stays high exactly 31 cycles, then done_o=err_o=1, cyc=0; a following read succeeds normally.
- Ack with wrong rid (tag=2, ack rid=5) for 4 cycles, then rid=2 -> first 4 acks ignored, completes on the matching ack.
- ce_i low for 10 cycles inside WAIT -> count frozen, outputs held; timeout occurs 10 cycles later than without stalls. 17 back-to-back reads -> tag wraps 15->0.
- rst_i pulsed during WAIT with ack asserted -> no done_o, next cycle cyc=0, tag=0, busy_o=0.
